// File: rtl/fetch_wait_stage_pkg.sv
// Shared definitions for the IF_wait stage: FSM state encoding and fetch exception codes.
package fetch_wait_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2,
        ST_FULL  = 2'd3
    } fws_state_e;

    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_TLBL = 5'h02;

endpackage

// File: rtl/fetch_wait_stage.sv
// IF_wait: holds one in-flight fetch, waits for the bus response and hands the
// instruction to decode; responses of cancelled fetches are absorbed silently.
module fetch_wait_stage
    import fetch_wait_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC_O = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ready_o,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        cancelled_i,
    input  logic        exc_i,
    input  logic        exc_miss_i,
    input  logic [4:0]  exccode_i,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        cancel_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        exc_o,
    output logic        exc_miss_o,
    output logic [4:0]  exccode_o,
    input  logic        ready_i
);

    fws_state_e state;
    fws_state_e load_state;
    logic       accept;
    logic       kill_in;

    assign ready_o = (state == ST_EMPTY)
                   | ((state == ST_FULL) & ready_i)
                   | ((state == ST_DROP) & inst_data_ok);
    assign accept  = valid_i & ready_o;
    assign valid_o = (state == ST_FULL);

    // A flush arriving with the entry kills it, but its bus request (if any) is still outstanding.
    always_comb begin
        kill_in = cancelled_i | cancel_i;
        if (exc_i) begin
            load_state = kill_in ? ST_EMPTY : ST_FULL;
        end else begin
            load_state = kill_in ? ST_DROP : ST_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_EMPTY;
            pc_o       <= RESET_PC_O;
            inst_o     <= '0;
            exc_o      <= 1'b0;
            exc_miss_o <= 1'b0;
            exccode_o  <= '0;
        end else if (accept) begin
            state      <= load_state;
            pc_o       <= pc_i;
            inst_o     <= '0;
            exc_o      <= exc_i;
            exc_miss_o <= exc_miss_i;
            exccode_o  <= exccode_i;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (inst_data_ok) begin
                        if (cancel_i) begin
                            state <= ST_EMPTY;
                        end else begin
                            state  <= ST_FULL;
                            inst_o <= inst_rdata;
                        end
                    end else if (cancel_i) begin
                        state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (inst_data_ok) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (cancel_i || ready_i) begin
                        state <= ST_EMPTY;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fetch_wait_stage.md
Name: fetch_wait_stage

Overview:
Second half of instruction fetch (IF_wait). It accepts one in-flight fetch from the IF_req stage after that stage's address handshake. It waits for the bus read response (inst_data_ok/inst_rdata) and registers the instruction word. It then hands pc, instruction and exception info to decode under a valid/ready handshake. Responses for cancelled fetches are absorbed and discarded, because the bus cannot cancel a request.

Parameters:
RESET_PC_O, 32'd0, value driven on pc_o after reset.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
ready_o  output  1  to IF_req: can accept an entry this cycle
valid_i  input  1  IF_req entry valid
pc_i  input  32  entry pc
cancelled_i  input  1  entry already cancelled upstream
exc_i  input  1  entry carries a fetch exception (no bus transaction issued)
exc_miss_i  input  1  TLB refill flavour of exception
exccode_i  input  5  exception code
inst_data_ok  input  1  bus read response valid
inst_rdata  input  32  bus read data
cancel_i  input  1  pipeline flush (exception/eret)
valid_o  output  1  to decode: instruction valid
pc_o  output  32  instruction pc
inst_o  output  32  instruction word (0 for exception entries)
exc_o  output  1  fetch exception
exc_miss_o  output  1  TLB refill
exccode_o  output  5  exception code
ready_i  input  1  decode accepts

Behaviour:
- Single entry. FSM states:
  - EMPTY
  - WAIT: bus request outstanding, entry live
  - DROP: bus request outstanding, entry dead
  - FULL: holding a result for decode
- Reset: state=EMPTY; valid_o=0, pc_o=RESET_PC_O, inst_o=0, exc_o=0, exc_miss_o=0, exccode_o=0. Reset mid-operation abandons any outstanding response. The surrounding core resets the bus in the same cycle.
- ready_o = EMPTY | (FULL & ready_i) | (DROP & inst_data_ok). ready_o is never asserted in WAIT.
- Accept = valid_i & ready_o. At accept, pc and exc fields are latched. Next state:
  - exc_i=1 & !(cancelled_i|cancel_i): FULL, inst_o=0, no bus wait.
  - exc_i=1 & (cancelled_i|cancel_i): EMPTY (discarded).
  - exc_i=0 & !(cancelled_i|cancel_i): WAIT.
  - exc_i=0 & (cancelled_i|cancel_i): DROP.
- WAIT:
  - inst_data_ok & !cancel_i: inst_o<=inst_rdata, go to FULL. valid_o rises the next cycle (latency 1 from data_ok).
  - cancel_i & !inst_data_ok: go to DROP.
  - cancel_i & inst_data_ok in the same cycle: go to EMPTY (response consumed, discarded).
- DROP: inst_data_ok: go to EMPTY, or load a new accepted entry in the same cycle per the accept rules. cancel_i has no effect.
- FULL: valid_o=1.
  - ready_i: entry leaves; go to EMPTY, or load the new accepted entry.
  - cancel_i: go to EMPTY regardless of ready_i. Decode also sees cancel_i and ignores a transfer in that cycle.
- valid_o is 1 only in FULL. Outputs are stable while FULL & !ready_i.
- inst_data_ok in EMPTY or FULL is a protocol error. The bench flags it; the RTL ignores it.
- Cancel precedence for a new entry: the incoming entry is treated as cancelled, and the outgoing FULL entry is cleared.

Decomposition:
- Shared package/header (common.vh): state encodings for EMPTY/WAIT/DROP/FULL (2-bit), plus the EXC_ADEL/EXC_TLBL codes already defined there.
- No sub-module. The FSM and the output register live in one module.

Test Plan:
- Normal fetch: accept pc=0xBFC00000; inst_data_ok with rdata=0x24020001 three cycles later -> valid_o=1 next cycle with inst_o=0x24020001; ready_i=1 -> EMPTY, ready_o=1.
- Back-to-back with stall: FULL, ready_i=0 for 4 cycles -> outputs stable, ready_o=0. Then ready_i=1 with valid_i pc=0xBFC00004 -> new entry enters WAIT in the same cycle.
- Exception entry: valid_i, exc_i=1, exccode_i=EXC_ADEL, pc=0xBFC00002 -> valid_o next cycle, exc_o=1, inst_o=0, no data_ok wait.
- Flush while waiting: in WAIT, cancel_i=1 -> DROP, ready_o=0. Later data_ok with rdata=0xDEADBEEF -> never on valid_o, and ready_o=1 in that cycle.
- Cancelled entry accepted: valid_i, cancelled_i=1, exc_i=0 -> DROP. Then data_ok and a new valid_i in the same cycle -> new entry in WAIT, only the second instruction emitted.
- Reset mid-WAIT: reset=1 -> next cycle valid_o=0, pc_o=RESET_PC_O, ready_o=1.
